// File: rtl/load_unit_if.sv
// Bundle of execute-stage request, data-memory read port and writeback result for load_unit.
// Handshake: mem_rd_req_in is a request sampled only while the unit is idle; dm_rd_req_out is
// level-held with dm_addr_out stable until dm_rd_ack_in is seen high on a rising clock edge
// (dm_data_in is valid in that same cycle); lu_valid_out is a one-cycle pulse, not a handshake.
interface load_unit_if;
  logic        mem_rd_req_in;
  logic [2:0]  func3_in;
  logic [31:0] iadder_in;
  logic        dm_rd_req_out;
  logic [31:0] dm_addr_out;
  logic        dm_rd_ack_in;
  logic [31:0] dm_data_in;
  logic [31:0] lu_output_out;
  logic        lu_valid_out;
  logic        stall_out;
  logic        misaligned_out;
  logic        bus_err_out;
  logic        state_dbg;

  modport slave (
    input  mem_rd_req_in, func3_in, iadder_in, dm_rd_ack_in, dm_data_in,
    output dm_rd_req_out, dm_addr_out, lu_output_out, lu_valid_out,
           stall_out, misaligned_out, bus_err_out, state_dbg
  );

  modport master (
    output mem_rd_req_in, func3_in, iadder_in, dm_rd_ack_in, dm_data_in,
    input  dm_rd_req_out, dm_addr_out, lu_output_out, lu_valid_out,
           stall_out, misaligned_out, bus_err_out, state_dbg
  );
endinterface

// File: rtl/load_unit.sv
// Load unit: issues a held data-memory read, aligns/extends the returned word, pulses valid.
// Optional bus timeout is compiled in with `define LU_TIMEOUT_EN.
module load_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic       clk_in,
  input logic       rst_n_in,
  load_unit_if.slave lu
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [2:0]  func3_q;
  logic [1:0]  off_q;
  logic [31:0] addr_q;
  logic [31:0] out_q, out_d;
  logic        valid_q, valid_d;
  logic        mis_q, mis_d;
  logic        err_q, err_d;
  logic        misaligned;
  logic        accept;
  logic        timeout;
  logic [31:0] extracted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // func3[1] set means word access; reserved encodings fall into that class too.
  assign misaligned = lu.func3_in[1] ? (lu.iadder_in[1:0] != 2'b00)
                                     : (lu.func3_in[0] & lu.iadder_in[0]);
  assign accept     = (state_q == IDLE) & lu.mem_rd_req_in & ~misaligned;

  always_comb begin
    byte_sel  = lu.dm_data_in[7:0];
    extracted = lu.dm_data_in;
    case (off_q)
      2'b00:   byte_sel = lu.dm_data_in[7:0];
      2'b01:   byte_sel = lu.dm_data_in[15:8];
      2'b10:   byte_sel = lu.dm_data_in[23:16];
      default: byte_sel = lu.dm_data_in[31:24];
    endcase
    half_sel = off_q[1] ? lu.dm_data_in[31:16] : lu.dm_data_in[15:0];
    if (func3_q[1])
      extracted = lu.dm_data_in;
    else if (func3_q[0])
      extracted = {{16{~func3_q[2] & half_sel[15]}}, half_sel};
    else
      extracted = {{24{~func3_q[2] & byte_sel[7]}}, byte_sel};
  end

`ifdef LU_TIMEOUT_EN
  logic [7:0] cnt_q;

  assign timeout = (state_q == WAIT) & ~lu.dm_rd_ack_in &
                   (cnt_q == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      cnt_q <= 8'd0;
    else if (accept)
      cnt_q <= 8'd0;
    else if ((state_q == WAIT) && !lu.dm_rd_ack_in)
      cnt_q <= cnt_q + 8'd1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (lu.mem_rd_req_in) begin
          if (misaligned) mis_d   = 1'b1;
          else            state_d = WAIT;
        end
      end
      WAIT: begin
        // An acknowledge in the final timeout cycle still completes normally.
        if (lu.dm_rd_ack_in) begin
          valid_d = 1'b1;
          out_d   = extracted;
          state_d = IDLE;
        end else if (timeout) begin
          err_d   = 1'b1;
          out_d   = 32'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      func3_q <= 3'd0;
      off_q   <= 2'd0;
      addr_q  <= 32'd0;
      out_q   <= 32'd0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      if (accept) begin
        func3_q <= lu.func3_in;
        off_q   <= lu.iadder_in[1:0];
        addr_q  <= lu.iadder_in;
      end
    end
  end

  assign lu.dm_rd_req_out  = (state_q == WAIT);
  assign lu.dm_addr_out    = addr_q;
  assign lu.lu_output_out  = out_q;
  assign lu.lu_valid_out   = valid_q;
  assign lu.stall_out      = (state_q == WAIT) | accept;
  assign lu.misaligned_out = mis_q;
  assign lu.bus_err_out    = err_q;
  assign lu.state_dbg      = state_q;

endmodule

// File: tb/tb_load_unit.sv
// Directed plus randomized bench for load_unit with a byte-shift reference model.
module tb_load_unit;
  localparam int unsigned TO = 16;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;
  int   total    = 0;
  int   bad      = 0;
  logic [31:0] last_out = 32'd0;
  logic [31:0] exp_q[$];

  load_unit_if bus ();

  load_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .lu      (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    if (f3[1]) return 4;
    if (f3[0]) return 2;
    return 1;
  endfunction

  function automatic bit model_mis(input logic [2:0] f3, input logic [31:0] addr);
    return (addr % acc_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] model_data(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] data);
    int          sz;
    logic [31:0] sh, mask, v;
    sz = acc_size(f3);
    if (sz == 4) return data;
    sh   = data >> (8 * (addr % 4));
    mask = (sz == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
    v    = sh & mask;
    if (!f3[2] && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic idle_check();
    step();
    chk("idle_valid", 32'(bus.lu_valid_out), 32'd0);
    chk("idle_mis", 32'(bus.misaligned_out), 32'd0);
    chk("idle_err", 32'(bus.bus_err_out), 32'd0);
    chk("idle_req", 32'(bus.dm_rd_req_out), 32'd0);
    chk("idle_stall", 32'(bus.stall_out), 32'd0);
    chk("idle_hold", bus.lu_output_out, last_out);
  endtask

  // Called at the start of a cycle; returns in the cycle the result (or misaligned) pulse is visible.
  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, input int delay);
    bit mis;
    logic [31:0] exp;
    mis = model_mis(f3, addr);
    bus.mem_rd_req_in = 1'b1;
    bus.func3_in      = f3;
    bus.iadder_in     = addr;
    #1;
    chk("stall_accept", 32'(bus.stall_out), 32'(!mis));
    step();
    bus.mem_rd_req_in = 1'b0;
    bus.func3_in      = 3'($urandom);
    bus.iadder_in     = $urandom;
    if (mis) begin
      chk("mis_pulse", 32'(bus.misaligned_out), 32'd1);
      chk("mis_noreq", 32'(bus.dm_rd_req_out), 32'd0);
      chk("mis_nostall", 32'(bus.stall_out), 32'd0);
      chk("mis_novalid", 32'(bus.lu_valid_out), 32'd0);
      chk("mis_hold", bus.lu_output_out, last_out);
      return;
    end
    exp_q.push_back(model_data(f3, addr, data));
    for (int i = 0; i < delay; i++) begin
      chk("wait_req", 32'(bus.dm_rd_req_out), 32'd1);
      chk("wait_addr", bus.dm_addr_out, addr);
      chk("wait_stall", 32'(bus.stall_out), 32'd1);
      chk("wait_novalid", 32'(bus.lu_valid_out), 32'd0);
      chk("wait_state", 32'(bus.state_dbg), 32'd1);
      bus.dm_data_in = $urandom;
      step();
    end
    chk("ack_req", 32'(bus.dm_rd_req_out), 32'd1);
    chk("ack_addr", bus.dm_addr_out, addr);
    bus.dm_rd_ack_in = 1'b1;
    bus.dm_data_in   = data;
    #1;
    chk("ack_stall", 32'(bus.stall_out), 32'd1);
    step();
    bus.dm_rd_ack_in = 1'b0;
    bus.dm_data_in   = $urandom;
    exp = exp_q.pop_front();
    chk("res_valid", 32'(bus.lu_valid_out), 32'd1);
    chk("res_data", bus.lu_output_out, exp);
    chk("res_req", 32'(bus.dm_rd_req_out), 32'd0);
    last_out = exp;
  endtask

  logic [2:0] f3_tab [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

  initial begin
    logic [2:0]  f3;
    logic [31:0] addr;
    bus.mem_rd_req_in = 1'b0;
    bus.func3_in      = 3'd0;
    bus.iadder_in     = 32'd0;
    bus.dm_rd_ack_in  = 1'b0;
    bus.dm_data_in    = 32'd0;

    // Reset state
    #2;
    chk("rst_req", 32'(bus.dm_rd_req_out), 32'd0);
    chk("rst_addr", bus.dm_addr_out, 32'd0);
    chk("rst_out", bus.lu_output_out, 32'd0);
    chk("rst_valid", 32'(bus.lu_valid_out), 32'd0);
    chk("rst_stall", 32'(bus.stall_out), 32'd0);
    chk("rst_mis", 32'(bus.misaligned_out), 32'd0);
    chk("rst_err", 32'(bus.bus_err_out), 32'd0);
    chk("rst_state", 32'(bus.state_dbg), 32'd0);
    step();
    rst_n_in = 1'b1;
    step();

    // Directed extraction cases
    do_load(3'b000, 32'h0000_1003, 32'h80FF_1234, 0);
    chk("lb_value", bus.lu_output_out, 32'hFFFF_FF80);
    idle_check();
    do_load(3'b100, 32'h0000_1001, 32'h8421_F0A5, 0);
    chk("lbu_value", bus.lu_output_out, 32'h0000_00F0);
    idle_check();
    do_load(3'b101, 32'h0000_1002, 32'h8421_F0A5, 2);
    chk("lhu_value", bus.lu_output_out, 32'h0000_8421);
    idle_check();
    do_load(3'b001, 32'h0000_1002, 32'h8421_F0A5, 1);
    chk("lh_value", bus.lu_output_out, 32'hFFFF_8421);
    idle_check();

    // Delayed word, then back-to-back accept in the valid cycle
    do_load(3'b010, 32'h0000_2000, 32'hDEAD_BEEF, 5);
    chk("lw_value", bus.lu_output_out, 32'hDEAD_BEEF);
    do_load(3'b010, 32'h0000_2004, 32'h1234_5678, 0);
    chk("lw_b2b_value", bus.lu_output_out, 32'h1234_5678);
    idle_check();

    // Misaligned rejections
    do_load(3'b001, 32'h0000_3001, 32'h0, 0);
    idle_check();
    do_load(3'b010, 32'h0000_3002, 32'h0, 0);
    idle_check();

    // Ack in the last allowed WAIT cycle completes normally
    do_load(3'b010, 32'h0000_4000, 32'hCAFE_F00D, int'(TO) - 1);
    chk("late_ack_err", 32'(bus.bus_err_out), 32'd0);
    idle_check();

`ifdef LU_TIMEOUT_EN
    // Ack withheld: error pulse after TO WAIT cycles, result cleared
    bus.mem_rd_req_in = 1'b1;
    bus.func3_in      = 3'b010;
    bus.iadder_in     = 32'h0000_5000;
    step();
    bus.mem_rd_req_in = 1'b0;
    for (int i = 0; i < int'(TO); i++) begin
      chk("to_req", 32'(bus.dm_rd_req_out), 32'd1);
      chk("to_noerr", 32'(bus.bus_err_out), 32'd0);
      step();
    end
    chk("to_err", 32'(bus.bus_err_out), 32'd1);
    chk("to_out", bus.lu_output_out, 32'd0);
    chk("to_novalid", 32'(bus.lu_valid_out), 32'd0);
    chk("to_req_drop", 32'(bus.dm_rd_req_out), 32'd0);
    last_out = 32'd0;
    idle_check();
`endif

    // Reset during WAIT, ack arriving the next cycle
    bus.mem_rd_req_in = 1'b1;
    bus.func3_in      = 3'b010;
    bus.iadder_in     = 32'h0000_6000;
    step();
    bus.mem_rd_req_in = 1'b0;
    chk("rw_req", 32'(bus.dm_rd_req_out), 32'd1);
    rst_n_in = 1'b0;
    #1;
    chk("rw_req_drop", 32'(bus.dm_rd_req_out), 32'd0);
    chk("rw_stall", 32'(bus.stall_out), 32'd0);
    chk("rw_addr", bus.dm_addr_out, 32'd0);
    chk("rw_out", bus.lu_output_out, 32'd0);
    last_out = 32'd0;
    bus.dm_rd_ack_in = 1'b1;
    bus.dm_data_in   = 32'hFFFF_FFFF;
    step();
    rst_n_in = 1'b1;
    step();
    bus.dm_rd_ack_in = 1'b0;
    chk("rw_novalid", 32'(bus.lu_valid_out), 32'd0);
    chk("rw_noreq", 32'(bus.dm_rd_req_out), 32'd0);
    chk("rw_out2", bus.lu_output_out, 32'd0);
    idle_check();

    // Randomized loads against the model
    for (int n = 0; n < 60; n++) begin
      f3   = f3_tab[$urandom_range(0, 7)];
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(acc_size(f3)) - 32'd1);
      do_load(f3, addr, $urandom, $urandom_range(0, 3));
      if (model_mis(f3, addr) || $urandom_range(0, 1) == 0) idle_check();
    end
    idle_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
